// File: rtl/tt3_pkg.sv
// rtl/tt3_pkg.sv - shared state enum, vector count and bit-ordering helper for tt3 harnesses
package tt3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } tt3_state_e;

  localparam int TT3_NVEC = 8;

  // Vector k lands in bit 7-k so 000 is the MSB of the truth-table byte.
  function automatic logic [2:0] tt3_bit(input logic [2:0] k);
    return 3'(TT3_NVEC - 1) - k;
  endfunction

endpackage

// File: rtl/tt3_sweep_capture_if.sv
// rtl/tt3_sweep_capture_if.sv - sweep request / result handshake between a harness and the capture stage
interface tt3_sweep_capture_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       match;

  modport master (output start, input busy, input done, input table_out, input match);
  modport slave  (input start, output busy, output done, output table_out, output match);
endinterface

// File: rtl/tt3_sync.sv
// rtl/tt3_sync.sv - parameterless 2-flop synchroniser for the gate output (used under TT3_SYNC_EN)
module tt3_sync (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end
endmodule

// File: rtl/tt3_sweep_capture.sv
// rtl/tt3_sweep_capture.sv - drives 8 input vectors into a 3-input gate and captures its truth-table byte
// Optional TT3_SYNC_EN: route dut_out through a 2-flop synchroniser before sampling.
module tt3_sweep_capture
  import tt3_pkg::*;
#(
  parameter int         DWELL    = 4,
  parameter logic [7:0] EXPECTED = 8'h43
) (
  input  logic                       clk,
  input  logic                       rst,
  tt3_sweep_capture_if.slave         ctl,
  output logic                       in1,
  output logic                       in2,
  output logic                       in3,
  input  logic                       dut_out
);

  localparam int         CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [2:0] VEC_LAST = 3'(TT3_NVEC - 1);

  logic sample_bit;

`ifdef TT3_SYNC_EN
  if (DWELL < 3) begin : g_dwell_check
    $error("tt3_sweep_capture: DWELL must be >= 3 with TT3_SYNC_EN");
  end

  tt3_sync u_sync (
    .clk (clk),
    .d   (dut_out),
    .q   (sample_bit)
  );
`else
  if (DWELL < 1) begin : g_dwell_check
    $error("tt3_sweep_capture: DWELL must be >= 1");
  end

  assign sample_bit = dut_out;
`endif

  tt3_state_e    state, state_n;
  logic [2:0]    vec, vec_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    acc, acc_n;
  logic [7:0]    table_q, table_n;
  logic          match_q, match_n;
  logic          done_q, done_n;
  logic          busy_q;
  logic [2:0]    drive_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vec     <= 3'd0;
      cnt     <= '0;
      acc     <= 8'h00;
      table_q <= 8'h00;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      drive_q <= 3'b000;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      cnt     <= cnt_n;
      acc     <= acc_n;
      table_q <= table_n;
      match_q <= match_n;
      done_q  <= done_n;
      busy_q  <= (state_n == DRIVE);
      drive_q <= (state_n == DRIVE) ? vec_n : 3'b000;
    end
  end

  // Results publish on the edge that takes the last sample, so table_out is valid alongside done.
  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    acc_n   = acc;
    table_n = table_q;
    match_n = match_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ctl.start) begin
          state_n = DRIVE;
          vec_n   = 3'd0;
          cnt_n   = '0;
          acc_n   = 8'h00;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_n                = '0;
          acc_n[tt3_bit(vec)]  = sample_bit;
          if (vec == VEC_LAST) begin
            state_n = DONE;
            table_n = acc_n;
            match_n = (acc_n == EXPECTED);
            done_n  = 1'b1;
          end else begin
            vec_n = vec + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign {in1, in2, in3} = drive_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;
  assign ctl.table_out   = table_q;
  assign ctl.match       = match_q;

endmodule

// File: tb/tb_tt3_sweep_capture.sv
// tb/tb_tt3_sweep_capture.sv - directed table-driven bench for tt3_sweep_capture
module tb_tt3_sweep_capture;

  localparam int DA = 4;
`ifdef TT3_SYNC_EN
  localparam int DB = 3;
`else
  localparam int DB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt3_sweep_capture_if ctl_a ();
  tt3_sweep_capture_if ctl_b ();

  logic       in1_a, in2_a, in3_a, dut_out_a;
  logic       in1_b, in2_b, in3_b;
  logic       dut_out_b = 1'b1;
  logic [7:0] gate_code = 8'h43;

  assign dut_out_a = gate_code[3'd7 - {in1_a, in2_a, in3_a}];

  tt3_sweep_capture #(.DWELL(DA), .EXPECTED(8'h43)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .ctl     (ctl_a.slave),
    .in1     (in1_a),
    .in2     (in2_a),
    .in3     (in3_a),
    .dut_out (dut_out_a)
  );

  tt3_sweep_capture #(.DWELL(DB)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .ctl     (ctl_b.slave),
    .in1     (in1_b),
    .in2     (in2_b),
    .in3     (in3_b),
    .dut_out (dut_out_b)
  );

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_tab;
    logic       exp_match;
    bit         poke;
  } vec_t;

  vec_t       tbl [6];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] prev_tab = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep on dut_a; cycle n counts from the first cycle after start is sampled.
  task automatic sweep_a(input logic [7:0] code, input logic [7:0] exp_tab,
                         input logic exp_match, input bit poke);
    int lat = 0, done_cnt = 0, bad_seq = 0, bad_hold = 0;
    logic [7:0] got_tab = 8'h00;
    logic got_match = 1'b0;
    gate_code = code;
    ctl_a.start = 1'b1;
    tick();
    ctl_a.start = 1'b0;
    for (int n = 1; n <= 8 * DA + 3; n++) begin
      if (n <= 8 * DA) begin
        if ({in1_a, in2_a, in3_a} !== 3'((n - 1) / DA) || ctl_a.busy !== 1'b1) bad_seq++;
        if (ctl_a.table_out !== prev_tab) bad_hold++;
      end else begin
        if ({in1_a, in2_a, in3_a} !== 3'b000 || ctl_a.busy !== 1'b0) bad_seq++;
      end
      if (ctl_a.done === 1'b1) begin
        done_cnt++;
        lat = n;
        got_tab = ctl_a.table_out;
        got_match = ctl_a.match;
      end
      ctl_a.start = poke && (n == 10 || n == 8 * DA + 1);
      tick();
    end
    ctl_a.start = 1'b0;
    check("a_done_latency", lat, 8 * DA + 1);
    check("a_done_count", done_cnt, 1);
    check("a_table", got_tab, exp_tab);
    check("a_match", got_match, exp_match);
    check("a_in_busy_seq", bad_seq, 0);
    check("a_no_partial", bad_hold, 0);
    repeat (3) tick();
    check("a_table_hold", ctl_a.table_out, exp_tab);
    prev_tab = exp_tab;
  endtask

  initial begin
    int lat_b, bad_b, dcnt;
    logic [7:0] tab_b;

    tbl[0] = '{8'h43, 8'h43, 1'b1, 1'b0};
    tbl[1] = '{8'hC2, 8'hC2, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'hA5, 8'hA5, 1'b0, 1'b1};
    tbl[5] = '{8'h43, 8'h43, 1'b1, 1'b1};

    ctl_a.start = 1'b0;
    ctl_b.start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();

    check("rst_in_a", {in1_a, in2_a, in3_a}, 3'b000);
    check("rst_busy_a", ctl_a.busy, 1'b0);
    check("rst_done_a", ctl_a.done, 1'b0);
    check("rst_table_a", ctl_a.table_out, 8'h00);
    check("rst_match_a", ctl_a.match, 1'b0);
    check("rst_table_b", ctl_b.table_out, 8'h00);

    // dut_b: gate tied high, shortest dwell.
    lat_b = 0; bad_b = 0; tab_b = 8'h00;
    ctl_b.start = 1'b1;
    tick();
    ctl_b.start = 1'b0;
    for (int n = 1; n <= 8 * DB + 2; n++) begin
      if (n <= 8 * DB && {in1_b, in2_b, in3_b} !== 3'((n - 1) / DB)) bad_b++;
      if (ctl_b.done === 1'b1) begin
        lat_b = n;
        tab_b = ctl_b.table_out;
        check("b_match", ctl_b.match, 1'b0);
      end
      tick();
    end
    check("b_done_latency", lat_b, 8 * DB + 1);
    check("b_table", tab_b, 8'hFF);
    check("b_in_seq", bad_b, 0);

    for (int i = 0; i < 6; i++)
      sweep_a(tbl[i].code, tbl[i].exp_tab, tbl[i].exp_match, tbl[i].poke);

    // Reset while vector 5 is being driven.
    gate_code = 8'hC2;
    ctl_a.start = 1'b1;
    tick();
    ctl_a.start = 1'b0;
    repeat (21) tick();
    check("mid_vec5", {in1_a, in2_a, in3_a}, 3'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", ctl_a.busy, 1'b0);
    check("mid_rst_in", {in1_a, in2_a, in3_a}, 3'b000);
    check("mid_rst_table", ctl_a.table_out, 8'h00);
    check("mid_rst_match", ctl_a.match, 1'b0);
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (ctl_a.done === 1'b1) dcnt++;
      tick();
    end
    check("mid_rst_no_done", dcnt, 0);
    prev_tab = 8'h00;
    sweep_a(8'h43, 8'h43, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
